// File: rtl/controlador_flipflop_pkg.sv
// Shared definitions for the flipflop controller.
// Holds the FSM state encoding and the default widths of the
// toggle-period and toggle-count fields.
package controlador_flipflop_pkg;

   localparam int ANCHO_CONT_DEF = 3;
   localparam int ANCHO_TOG_DEF  = 4;

   typedef logic [1:0] estado_t;

   localparam estado_t ST_IDLE  = 2'd0;
   localparam estado_t ST_RUN   = 2'd1;
   localparam estado_t ST_CHECK = 2'd2;

endpackage

// File: rtl/contador_periodo.sv
// Period counter for the flipflop controller.
// Counts 0 .. limit-1 while enabled and wraps to 0 on the terminal count.
// A limit of 0 is treated as 1, so the count stays at 0 and the
// terminal-count flag is raised every enabled cycle.
//   clk    : clock, rising edge
//   rst    : synchronous active-high reset, clears the count
//   enable : advance the count this cycle
//   clear  : force the count back to 0 (takes priority over enable)
//   limit  : period length in cycles
//   count  : current count
//   tc     : count is at its last value (limit-1)
module contador_periodo
   import controlador_flipflop_pkg::*;
#(
   parameter int ANCHO = ANCHO_CONT_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             clear,
   input  logic [ANCHO-1:0] limit,
   output logic [ANCHO-1:0] count,
   output logic             tc
);

   // Last count value before wrapping; a zero limit saturates to one.
   function automatic logic [ANCHO-1:0] ultimo_valor(input logic [ANCHO-1:0] lim);
      return (lim == '0) ? '0 : lim - ANCHO'(1);
   endfunction

   assign tc = (count == ultimo_valor(limit));

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         count <= '0;
      end else if (enable) begin
         count <= tc ? '0 : count + ANCHO'(1);
      end
   end

endmodule

// File: rtl/controlador_flipflop.sv
// Controller that drives an external flipflop with a periodic toggle
// pattern and checks that the flipflop captures every value it is given.
//   clk, rst         : clock and synchronous active-high reset
//   i_start          : start a run (only looked at in IDLE)
//   i_stop           : end a run early (only looked at in RUN)
//   i_periodo        : cycles between toggles, latched at start (0 acts as 1)
//   i_num_toggles    : toggles per run, latched at start (0 = until i_stop)
//   i_valor_ff       : output of the controlled flipflop
//   o_valor_ff       : data input of the controlled flipflop
//   o_busy           : high in RUN and CHECK
//   o_done           : one-cycle pulse in the first IDLE cycle after a run
//   o_error          : sticky capture mismatch flag, cleared on start
//   o_cuenta_toggles : toggles issued in the current or last run
module controlador_flipflop
   import controlador_flipflop_pkg::*;
#(
   parameter int ANCHO_CONT = ANCHO_CONT_DEF,
   parameter int ANCHO_TOG  = ANCHO_TOG_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_start,
   input  logic                 i_stop,
   input  logic [ANCHO_CONT-1:0] i_periodo,
   input  logic [ANCHO_TOG-1:0]  i_num_toggles,
   input  logic                 i_valor_ff,
   output logic                 o_valor_ff,
   output logic                 o_busy,
   output logic                 o_done,
   output logic                 o_error,
   output logic [ANCHO_TOG-1:0]  o_cuenta_toggles
);

   estado_t                estado;
   logic [ANCHO_CONT-1:0]  periodo_q;
   logic [ANCHO_TOG-1:0]   num_q;
   logic                   chk_cnt;
   logic [ANCHO_CONT-1:0]  cuenta_periodo;
   logic                   tc;
   logic                   inicio;
   logic                   toggle;
   logic [ANCHO_TOG-1:0]   cuenta_next;
   logic                   ultimo_toggle;
   logic                   valor_p1;
   logic                   vld_p1;
   logic                   mismatch;

   assign inicio        = (estado == ST_IDLE) && i_start;
   assign toggle        = (estado == ST_RUN) && tc;
   assign cuenta_next   = o_cuenta_toggles + ANCHO_TOG'(1);
   assign ultimo_toggle = toggle && (num_q != '0) && (cuenta_next == num_q);

   // The flipflop shows last cycle's o_valor_ff; vld_p1 masks the first
   // RUN cycle, where no value has been presented yet.
   assign mismatch = (estado != ST_IDLE) && vld_p1 && (i_valor_ff != valor_p1);

   contador_periodo #(
      .ANCHO (ANCHO_CONT)
   ) u_contador_periodo (
      .clk    (clk),
      .rst    (rst),
      .enable (estado == ST_RUN),
      .clear  (inicio),
      .limit  (periodo_q),
      .count  (cuenta_periodo),
      .tc     (tc)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         estado           <= ST_IDLE;
         periodo_q        <= '0;
         num_q            <= '0;
         chk_cnt          <= 1'b0;
         valor_p1         <= 1'b0;
         vld_p1           <= 1'b0;
         o_valor_ff       <= 1'b0;
         o_busy           <= 1'b0;
         o_done           <= 1'b0;
         o_error          <= 1'b0;
         o_cuenta_toggles <= '0;
      end else begin
         if (estado == ST_RUN) begin
            assert ((cuenta_periodo < periodo_q) || (cuenta_periodo == '0));
         end

         // Compare stage: one-cycle delayed copy of the driven value
         valor_p1 <= o_valor_ff;
         vld_p1   <= (estado != ST_IDLE);
         o_done   <= 1'b0;
         if (mismatch) begin
            o_error <= 1'b1;
         end

         case (estado)
            ST_IDLE: begin
               if (i_start) begin
                  periodo_q        <= i_periodo;
                  num_q            <= i_num_toggles;
                  o_cuenta_toggles <= '0;
                  o_error          <= 1'b0;
                  o_valor_ff       <= 1'b1;
                  o_busy           <= 1'b1;
                  estado           <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (toggle) begin
                  o_valor_ff       <= ~o_valor_ff;
                  o_cuenta_toggles <= cuenta_next;
               end
               // A stop and a toggle on the same edge both take effect.
               if (i_stop || ultimo_toggle) begin
                  chk_cnt <= 1'b0;
                  estado  <= ST_CHECK;
               end
            end
            ST_CHECK: begin
               if (chk_cnt) begin
                  o_valor_ff <= 1'b0;
                  o_busy     <= 1'b0;
                  o_done     <= 1'b1;
                  estado     <= ST_IDLE;
               end else begin
                  chk_cnt <= 1'b1;
               end
            end
            default: begin
               estado <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_controlador_flipflop.sv
// Testbench for controlador_flipflop connected to a real flipflop model.
module tb_controlador_flipflop;

   logic       clk;
   logic       rst;
   logic       i_start;
   logic       i_stop;
   logic [2:0] i_periodo;
   logic [3:0] i_num_toggles;
   logic       i_valor_ff;
   logic       o_valor_ff;
   logic       o_busy;
   logic       o_done;
   logic       o_error;
   logic [3:0] o_cuenta_toggles;

   logic       ff_q;
   logic       forzar_cero;

   int n_cmp;
   int n_bad;

   typedef struct {
      logic start;
      int   valor;
      int   busy;
      int   done;
      int   error;
      int   cuenta;
   } vec_t;

   vec_t tbl[26];

   controlador_flipflop #(
      .ANCHO_CONT (3),
      .ANCHO_TOG  (4)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .i_start          (i_start),
      .i_stop           (i_stop),
      .i_periodo        (i_periodo),
      .i_num_toggles    (i_num_toggles),
      .i_valor_ff       (i_valor_ff),
      .o_valor_ff       (o_valor_ff),
      .o_busy           (o_busy),
      .o_done           (o_done),
      .o_error          (o_error),
      .o_cuenta_toggles (o_cuenta_toggles)
   );

   // Controlled flipflop, with an optional stuck-at-0 output
   always_ff @(posedge clk) begin
      if (rst) ff_q <= 1'b0;
      else     ff_q <= o_valor_ff;
   end
   assign i_valor_ff = forzar_cero ? 1'b0 : ff_q;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached before summary");
      $fatal(1, "time limit");
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input int c, input logic [31:0] act, input int exp);
      if (exp < 0) return;
      n_cmp++;
      if (act !== 32'(exp)) begin
         n_bad++;
         $display("FAIL %s cycle %0d: got %0d expected %0d", nm, c, act, exp);
      end
   endtask

   task automatic chk_all(input int c, input int v, input int b, input int d,
                          input int e, input int k);
      chk("o_valor_ff", c, 32'(o_valor_ff), v);
      chk("o_busy", c, 32'(o_busy), b);
      chk("o_done", c, 32'(o_done), d);
      chk("o_error", c, 32'(o_error), e);
      chk("o_cuenta_toggles", c, 32'(o_cuenta_toggles), k);
   endtask

   task automatic idle(input int n);
      i_start = 1'b0;
      i_stop  = 1'b0;
      repeat (n) next_cycle();
   endtask

   // Nominal run from the table; inject adds start pulses in RUN and CHECK
   // carrying different period/count values that must be ignored.
   task automatic apply_table(input bit inject, input string tag);
      bit extra;
      for (int c = 0; c < 26; c++) begin
         extra = inject && (c == 5 || c == 10 || c == 22 || c == 23);
         i_start       = tbl[c].start || extra;
         i_stop        = 1'b0;
         i_periodo     = tbl[c].start ? 3'd7 : 3'd2;
         i_num_toggles = tbl[c].start ? 4'd3 : 4'd1;
         @(negedge clk);
         chk_all(c, tbl[c].valor, tbl[c].busy, tbl[c].done, tbl[c].error, tbl[c].cuenta);
         if (c == 25) chk({tag, " o_cuenta_toggles final"}, c, 32'(o_cuenta_toggles), 3);
         next_cycle();
      end
      i_start = 1'b0;
   endtask

   initial begin
      int ev[9];
      int eb[9];
      int ed[9];

      n_cmp = 0;
      n_bad = 0;

      // Nominal run, periodo=7, num_toggles=3, start in cycle 0
      for (int c = 0; c < 26; c++) begin
         tbl[c].start  = (c == 0);
         tbl[c].valor  = ((c >= 1 && c <= 7) || (c >= 15 && c <= 21)) ? 1 : 0;
         tbl[c].busy   = (c >= 1 && c <= 23) ? 1 : 0;
         tbl[c].done   = (c == 0) ? -1 : ((c == 24) ? 1 : 0);
         tbl[c].error  = (c == 0) ? -1 : 0;
         tbl[c].cuenta = (c == 0) ? -1 : (c <= 7) ? 0 : (c <= 14) ? 1 : (c <= 21) ? 2 : 3;
      end

      rst           = 1'b1;
      i_start       = 1'b0;
      i_stop        = 1'b0;
      i_periodo     = '0;
      i_num_toggles = '0;
      forzar_cero   = 1'b0;

      // Reset state
      repeat (3) next_cycle();
      @(negedge clk);
      chk_all(0, 0, 0, 0, 0, 0);
      rst = 1'b0;
      next_cycle();
      @(negedge clk);
      chk_all(1, 0, 0, 0, 0, 0);
      next_cycle();

      // Nominal run
      apply_table(1'b0, "nominal");
      idle(2);

      // Broken capture: flipflop output stuck at 0
      forzar_cero = 1'b1;
      for (int c = 0; c < 27; c++) begin
         i_start       = (c == 0);
         i_periodo     = 3'd7;
         i_num_toggles = 4'd3;
         @(negedge clk);
         if (c >= 1) chk("broken o_error", c, 32'(o_error), (c >= 3) ? 1 : 0);
         next_cycle();
      end
      i_start = 1'b0;
      idle(3);
      @(negedge clk);
      chk("broken o_error sticky in IDLE", 30, 32'(o_error), 1);
      next_cycle();
      forzar_cero = 1'b0;

      // Nominal run with ignored starts; also shows o_error cleared by start
      apply_table(1'b1, "ignored start");
      idle(2);

      // Boundary period 0, start and stop together in IDLE
      ev = '{0, 1, 0, 1, 0, 1, 1, 0, 0};
      eb = '{0, 1, 1, 1, 1, 1, 1, 0, 0};
      ed = '{-1, 0, 0, 0, 0, 0, 0, 1, 0};
      for (int c = 0; c < 9; c++) begin
         i_start       = (c == 0);
         i_stop        = (c == 0);
         i_periodo     = 3'd0;
         i_num_toggles = 4'd4;
         @(negedge clk);
         chk_all(c, ev[c], eb[c], ed[c], (c == 0) ? -1 : 0, (c == 7) ? 4 : -1);
         next_cycle();
      end
      idle(2);

      // Free run with wrap, stopped in cycle 40
      for (int c = 0; c < 46; c++) begin
         i_start       = (c == 0);
         i_stop        = (c == 40);
         i_periodo     = 3'd2;
         i_num_toggles = 4'd0;
         @(negedge clk);
         case (c)
            3:  chk("free o_valor_ff", c, 32'(o_valor_ff), 0);
            31: chk("free o_cuenta_toggles", c, 32'(o_cuenta_toggles), 15);
            32: chk("free o_cuenta_toggles", c, 32'(o_cuenta_toggles), 15);
            33: chk("free o_cuenta_toggles wrap", c, 32'(o_cuenta_toggles), 0);
            35: chk("free o_busy", c, 32'(o_busy), 1);
            40: chk("free o_busy", c, 32'(o_busy), 1);
            41: chk_all(c, 1, 1, 0, 0, 4);
            42: chk_all(c, 1, 1, 0, 0, 4);
            43: chk_all(c, 0, 0, 1, 0, 4);
            44: chk_all(c, 0, 0, 0, 0, 4);
            default: ;
         endcase
         next_cycle();
      end
      idle(2);

      // Reset in cycle 10 of a run, then a nominal run started in cycle 12
      for (int c = 0; c < 12; c++) begin
         i_start       = (c == 0);
         i_stop        = 1'b0;
         i_periodo     = 3'd7;
         i_num_toggles = 4'd3;
         rst           = (c == 10);
         @(negedge clk);
         if (c == 10) chk_all(c, 0, 1, 0, 0, 1);
         if (c == 11) chk_all(c, 0, 0, 0, 0, 0);
         next_cycle();
      end
      rst = 1'b0;
      apply_table(1'b0, "after reset");
      idle(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/controlador_flipflop.md
CONTROLADOR_FLIPFLOP -- requirements
Module: controlador_flipflop

Interface
REQ-001 Parameter ANCHO_CONT, default 3, SHALL set the width of the toggle-period field and internal period counter.
REQ-002 Parameter ANCHO_TOG, default 4, SHALL set the width of the toggle-count field and toggle counter.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on rising edge.
REQ-004 rst  input  1  SHALL be a synchronous, active-high reset.
REQ-005 i_start  input  1  SHALL request a new run; sampled only in IDLE.
REQ-006 i_stop  input  1  SHALL request early termination; sampled only in RUN.
REQ-007 i_periodo  input  ANCHO_CONT  SHALL give the cycles between toggles; latched on accepted start.
REQ-008 i_num_toggles  input  ANCHO_TOG  SHALL give the toggles per run (0 = run until i_stop); latched on accepted start.
REQ-009 i_valor_ff  input  1  SHALL carry the o_valor output of the controlled flipflop.
REQ-010 o_valor_ff  output  1  SHALL drive the i_valor input of the controlled flipflop.
REQ-011 o_busy  output  1  SHALL be high while in RUN or CHECK.
REQ-012 o_done  output  1  SHALL be a one-cycle completion pulse.
REQ-013 o_error  output  1  SHALL be a sticky capture-mismatch flag.
REQ-014 o_cuenta_toggles  output  ANCHO_TOG  SHALL report the toggles issued in the current or last run.

Function
REQ-015 FSM states IDLE, RUN, CHECK SHALL be the only states; all outputs SHALL be registered.
REQ-016 IDLE with i_start=1 SHALL latch i_periodo and i_num_toggles and clear period counter, toggle counter and o_error. It SHALL enter RUN with o_valor_ff=1.
REQ-017 i_start SHALL be ignored outside IDLE; in IDLE, i_start wins over a simultaneous i_stop.
REQ-018 In RUN the period counter SHALL increment each cycle. At count == periodo-1 it SHALL clear to 0, toggle o_valor_ff and increment o_cuenta_toggles, all on the same edge.
REQ-019 A latched periodo of 0 SHALL behave as 1 (toggle every cycle); the counter SHALL never exceed periodo-1.
REQ-020 On the edge issuing toggle number num_toggles (num_toggles != 0), or any RUN edge with i_stop=1, the next state SHALL be CHECK; i_stop and a toggle on the same edge SHALL apply both.
REQ-021 o_cuenta_toggles SHALL wrap modulo 2^ANCHO_TOG when num_toggles=0.
REQ-022 CHECK SHALL last exactly 2 cycles with o_valor_ff held, then return to IDLE. o_done=1 and o_valor_ff=0 in the first IDLE cycle.
REQ-023 In every RUN/CHECK cycle except the first RUN cycle, i_valor_ff SHALL be compared with the previous cycle's o_valor_ff; a mismatch SHALL set o_error on the next edge.
REQ-024 o_error SHALL stay set until the next accepted start or reset; o_cuenta_toggles SHALL hold its value in IDLE until the next accepted start.

Reset
REQ-025 rst=1 at any edge, including mid-RUN/CHECK, SHALL force IDLE. It SHALL set o_valor_ff=0, o_busy=0, o_done=0, o_error=0, o_cuenta_toggles=0, clear the counters and the delayed-compare register, and suppress any pending o_done.

Structure
REQ-026 A shared package SHALL hold the state encoding (IDLE, RUN, CHECK) and the default ANCHO_CONT/ANCHO_TOG constants.
REQ-027 The period counter SHALL be one sub-module, contador_periodo: inputs clk, rst, enable, clear and limit; outputs the count and a terminal-count flag.

Verification
REQ-028 The bench SHALL connect the block to a real flipflop and cover the following directed scenarios.
REQ-029 Nominal run: start at cycle 0, periodo=7, num_toggles=3 -> o_valor_ff=1 in cycles 1-7, 0 in 8-14, 1 in 15-21, 0 from 22. Also: CHECK in cycles 22-23; o_busy in 1-23; o_done only in cycle 24; o_error=0; o_cuenta_toggles=3.
REQ-030 Broken capture: i_valor_ff forced 0, periodo=7, num_toggles=3 -> o_error=1 from cycle 3 until the next accepted start.
REQ-031 Boundary period: periodo=0, num_toggles=4 -> o_valor_ff toggles every cycle (1,0,1,0,1), then CHECK 2 cycles, then o_done; o_error=0.
REQ-032 Free run: num_toggles=0, periodo=2 -> run continues past 16 toggles with o_cuenta_toggles wrapping 15->0. With i_stop at cycle 40 -> CHECK in cycles 41-42, o_done in cycle 43.
REQ-033 Reset mid-run: rst at cycle 10 of a periodo=7 run -> cycle 11 shows IDLE, all outputs 0, no o_done. A start at cycle 12 then behaves exactly as the nominal-run scenario.
REQ-034 Ignored start: i_start pulsed during RUN and CHECK -> no effect on counters, latched fields or outputs.
